// File: rtl/map_reader.sv
// map_reader: snapshots a tile map on entering play, counts its walls one row per cycle,
// then serves single-cycle-latency tile queries from the snapshot.
module map_reader #(
  parameter int MAP_W = 64,
  parameter int MAP_H = 44
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             i_top_state,
  input  logic [MAP_W*MAP_H-1:0] i_map,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic [5:0]             i_req_x,
  input  logic [5:0]             i_req_y,
  output logic                   o_rsp_valid,
  output logic                   o_rsp_tile,
  output logic                   o_rsp_oob,
  output logic                   o_loaded,
  output logic [11:0]            o_wall_count
);
  localparam int RW = $clog2(MAP_H);
  localparam int SW = $clog2(MAP_W*MAP_H);
  typedef enum logic [1:0] {IDLE, SCAN, SERVE} state_t;
  state_t                 r_state, w_next;
  logic [MAP_W*MAP_H-1:0] r_snap;
  logic [RW-1:0]          r_row;
  logic [11:0]            r_acc, r_wall, w_sum;
  logic                   r_rsp_valid, r_rsp_tile, r_rsp_oob;
  logic                   w_play, w_last, w_accept, w_oob;
  logic [SW-1:0]          w_idx;
  assign w_play      = i_top_state == 2'b10;
  assign w_last      = r_row == RW'(MAP_H-1);
  assign w_sum       = r_acc + 12'($countones(r_snap[MAP_W*r_row +: MAP_W]));
  assign w_accept    = i_req_valid && r_state == SERVE;
  assign w_oob       = int'(i_req_y) >= MAP_H;
  // Truncation only matters for out-of-range rows, whose tile is forced to 0 anyway.
  assign w_idx       = SW'(int'(i_req_y) * MAP_W + int'(i_req_x));
  assign o_loaded    = r_state == SERVE;
  assign o_req_ready = r_state == SERVE;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_tile  = r_rsp_tile;
  assign o_rsp_oob   = r_rsp_oob;
  assign o_wall_count = r_wall;
  always_comb begin
    w_next = !w_play ? IDLE :
             r_state == IDLE ? SCAN :
             (r_state == SCAN && w_last) ? SERVE : r_state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap      <= '0;
      r_row       <= '0;
      r_acc       <= '0;
      r_wall      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_tile  <= 1'b0;
      r_rsp_oob   <= 1'b0;
    end else begin
      if (r_state == IDLE && w_play) begin
        r_snap <= i_map;
        r_row  <= '0;
        r_acc  <= '0;
      end else if (r_state == SCAN) begin
        r_row <= r_row + 1'b1;
        r_acc <= w_sum;
        // An aborted scan must not publish a partial count.
        if (w_last && w_play) r_wall <= w_sum;
      end
      r_rsp_valid <= w_accept;
      if (w_accept) begin
        r_rsp_tile <= !w_oob && r_snap[w_idx];
        r_rsp_oob  <= w_oob;
      end
    end
  end
endmodule

// File: tb/tb_map_reader.sv
// tb_map_reader: randomized scoreboard bench for map_reader against a snapshot/popcount model.
module tb_map_reader;
  localparam int MAP_W = 64;
  localparam int MAP_H = 44;
  logic                   clk = 0;
  logic                   rst_n = 1;
  logic [1:0]             i_top_state = 0;
  logic [MAP_W*MAP_H-1:0] i_map = '0;
  logic                   i_req_valid = 0;
  logic [5:0]             i_req_x = 0, i_req_y = 0;
  logic                   o_req_ready, o_rsp_valid, o_rsp_tile, o_rsp_oob, o_loaded;
  logic [11:0]            o_wall_count;
  logic [MAP_W*MAP_H-1:0] m_snap = '0;
  logic                   m_serve = 0;
  logic [1:0]             exp_q[$];
  logic [1:0]             last_rsp = 0;
  int                     n_cmp = 0, n_bad = 0;
  int                     prev_wall;

  map_reader #(.MAP_W(MAP_W), .MAP_H(MAP_H)) dut (
    .clk(clk), .rst_n(rst_n), .i_top_state(i_top_state), .i_map(i_map),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_x(i_req_x), .i_req_y(i_req_y),
    .o_rsp_valid(o_rsp_valid), .o_rsp_tile(o_rsp_tile), .o_rsp_oob(o_rsp_oob),
    .o_loaded(o_loaded), .o_wall_count(o_wall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic query(input int x, input int y);
    i_req_valid = 1;
    i_req_x = 6'(x);
    i_req_y = 6'(y);
    if (m_serve) exp_q.push_back(y >= MAP_H ? 2'b01 : {m_snap[y*MAP_W + x], 1'b0});
    tick();
    i_req_valid = 0;
  endtask

  // Enter play from IDLE; the whole map must be scanned before queries are served.
  task automatic play_scan();
    int n;
    i_top_state = 2'b10;
    m_snap = i_map;
    tick();
    n = 0;
    while (!o_loaded && n < 100) begin
      check("ready_during_scan", o_req_ready, 0);
      tick();
      n++;
    end
    check("scan_cycles", n, MAP_H);
    check("wall_count", o_wall_count, $countones(m_snap));
    m_serve = 1;
  endtask

  task automatic random_queries(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      else query($urandom_range(0, MAP_W-1), $urandom_range(0, 63));
    end
  endtask

  // Monitor: every response pops the oldest expectation; idle cycles must hold the last response.
  always @(negedge clk) begin
    if (!rst_n) last_rsp = 0;
    else if (o_rsp_valid) begin
      if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
      else check("rsp_tile_oob", {o_rsp_tile, o_rsp_oob}, exp_q.pop_front());
      last_rsp = {o_rsp_tile, o_rsp_oob};
    end else check("rsp_hold", {o_rsp_tile, o_rsp_oob}, last_rsp);
  end

  initial begin
    #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wall", o_wall_count, 0);
    check("rst_loaded", o_loaded, 0);
    check("rst_ready", o_req_ready, 0);
    check("rst_rsp", {o_rsp_valid, o_rsp_tile, o_rsp_oob}, 0);
    rst_n = 1;
    repeat (3) tick();
    check("idle_loaded", o_loaded, 0);

    i_map[0 +: MAP_W] = 64'hFF;
    i_map[MAP_W*43 + 63] = 1'b1;
    play_scan();
    check("wall_nine", o_wall_count, 9);
    check("serve_ready", o_req_ready, 1);
    query(63, 43);
    query(8, 0);
    query(0, 44);
    query(5, 63);
    tick();
    random_queries(60);

    i_map = '1;
    query(1, 1);
    i_top_state = 2'b00;
    query(63, 43);
    m_serve = 0;
    check("drop_loaded", o_loaded, 0);
    check("drop_ready", o_req_ready, 0);
    tick();
    play_scan();
    check("wall_full", o_wall_count, 2816);
    query(1, 1);
    random_queries(30);

    i_top_state = 2'b00;
    m_serve = 0;
    tick();
    for (int i = 0; i < MAP_W*MAP_H; i++) i_map[i] = 1'($urandom_range(0, 1));
    play_scan();
    random_queries(80);

    i_top_state = 2'b00;
    m_serve = 0;
    tick();
    prev_wall = o_wall_count;
    for (int i = 0; i < MAP_W*MAP_H; i++) i_map[i] = 1'($urandom_range(0, 1));
    i_top_state = 2'b10;
    tick();
    repeat (20) tick();
    check("scan_wall_hold", o_wall_count, prev_wall);
    i_top_state = 2'b00;
    tick();
    check("abort_loaded", o_loaded, 0);
    check("abort_ready", o_req_ready, 0);
    check("abort_wall", o_wall_count, prev_wall);
    repeat (3) tick();
    check("abort_wall_idle", o_wall_count, prev_wall);

    play_scan();
    i_req_valid = 1;
    i_req_x = 3;
    i_req_y = 3;
    #2 rst_n = 0;
    #1;
    check("arst_wall", o_wall_count, 0);
    check("arst_loaded", o_loaded, 0);
    check("arst_ready", o_req_ready, 0);
    check("arst_rsp", {o_rsp_valid, o_rsp_tile, o_rsp_oob}, 0);
    m_serve = 0;
    tick();
    i_req_valid = 0;
    i_top_state = 2'b00;
    rst_n = 1;
    repeat (4) begin
      tick();
      check("post_rst_valid", o_rsp_valid, 0);
    end
    check("post_rst_loaded", o_loaded, 0);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
